despachante_ativos: RTL and testbench
=====================================

Name: despachante_ativos

Overview:
- Downstream of gerenciador_ativos. Consumes its habilitar vector (one bit per NA, meaning the NA is enabled and pending).
- Picks one enabled NA per transaction using round-robin arbitration and offers that NA's index and address on a valid/ready interface to the processing stage.
- After the offer is accepted, pulses desativar_out with the same address, which feeds gerenciador_ativos.desativar_in so that the NA is retired.

Parameters:
- NUM_NA, 8, number of NAs; must be ≥2.
- ADR_WIDTH, 5, width of each NA address.
- SEL_WIDTH, $clog2(NUM_NA) (localparam), width of the NA index.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- habilitar_in  in  NUM_NA  enabled/pending NA vector, from gerenciador_ativos habilitar_out.
- na_endereco_in  in  ADR_WIDTH*NUM_NA  packed NA addresses; NA i occupies bits [i*ADR_WIDTH +: ADR_WIDTH].
- pronto_in  in  1  downstream ready.
- valido_out  out  1  offer valid.
- na_sel_out  out  SEL_WIDTH  index of the offered NA.
- endereco_out  out  ADR_WIDTH  address of the offered NA.
- desativar_out  out  1  one-cycle retire pulse to gerenciador_ativos.
- ocupado_out  out  1  high in any state other than OCIOSO.
- contagem_out  out  16  dispatch counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at posedge):
  - state=OCIOSO, round-robin pointer ptr=0.
  - All outputs 0: valido_out, na_sel_out, endereco_out, desativar_out, ocupado_out, contagem_out.
  - Reset has priority over everything. A reset during OFERTA or DESATIVA aborts the transaction, so no desativar pulse is issued.
- Arbitration (combinational, in OCIOSO only):
  - Winner is the first set bit of habilitar_in found by searching upward from ptr and wrapping past NUM_NA-1 to 0.
- FSM states: OCIOSO, OFERTA, DESATIVA, GUARDA.
- OCIOSO:
  - If habilitar_in==0, stay.
  - Otherwise, at the clock edge: register winner into na_sel_out and its slice of na_endereco_in into endereco_out; set valido_out=1; go to OFERTA.
  - Latency from a bit rising in habilitar_in to valido_out=1 is 1 cycle.
- OFERTA:
  - valido_out=1. na_sel_out and endereco_out are held stable and do not track changes to habilitar_in or na_endereco_in.
  - The offer is never retracted, even if habilitar_in[na_sel_out] drops.
  - On valido_out & pronto_in at a posedge: valido_out←0, desativar_out←1, ptr←(na_sel_out+1) mod NUM_NA, go to DESATIVA.
  - pronto_in already high on entry to OFERTA means acceptance on the first OFERTA cycle.
- DESATIVA:
  - desativar_out=1 for exactly 1 cycle; endereco_out still holds the retired address.
  - Next edge: desativar_out←0, go to GUARDA.
- GUARDA:
  - One dead cycle so that gerenciador_ativos can clear the retired bit before the next arbitration.
  - Next edge: go to OCIOSO.
- Throughput: at most one dispatch per 4 cycles when pronto_in is held high.
- Wrap-around:
  - ptr=NUM_NA-1 after a grant wraps to 0.
  - A single enabled bit is granted repeatedly regardless of ptr.
- ocupado_out = (state != OCIOSO), registered alongside state.
- Outside valido_out/desativar_out windows, na_sel_out and endereco_out keep their last value. The bench must not check them there.

Optional Feature:
- Macro DESPACHANTE_CONTADOR_EN.
- Defined: contagem_out is a 16-bit counter, cleared by rst, incremented on each accepted offer (valido_out & pronto_in). Wraps 0xFFFF→0x0000.
- Undefined: contagem_out is tied to 0 and no counter flops are built. Port list is identical in both builds.

Test Plan:
- Reset mid-offer: enter OFERTA on NA 2, hold pronto_in=0, assert rst for 1 cycle -> all outputs 0 next cycle; no desativar_out pulse; ptr=0, so NA 1 wins the next arbitration when habilitar_in=8'b0000_0110.
- Single NA: after reset, habilitar_in=8'b0010_0000, NA5 address=5'd17, pronto_in=1 -> valido_out=1, na_sel_out=5, endereco_out=17 one cycle later; accepted on the first OFERTA cycle; desativar_out pulses 1 cycle with endereco_out=17; ocupado_out high for 3 cycles.
- Round-robin: habilitar_in=8'hFF held, pronto_in=1 -> grants in order 0,1,2,…,7,0, spaced 4 cycles apart.
- Backpressure: habilitar_in=8'b0000_1001, pronto_in=0 for 6 cycles then 1 -> na_sel_out=0 with valido_out stable for 6 cycles; clear bit 0 during the wait -> offer still held; after acceptance the next grant is NA 3.
- Wrap from top: ptr=7 (after granting NA 6), habilitar_in=8'b0000_0011 -> winner NA 0, then NA 1.
- Counter with DESPACHANTE_CONTADOR_EN: 3 accepted offers -> contagem_out=3. Force 65536 acceptances -> contagem_out=0. Without the macro, contagem_out stays 0 throughout.

Source files
------------

// File: rtl/despachante_ativos.sv
// despachante_ativos: round-robin dispatcher for enabled NAs.
// Picks one pending NA from habilitar_in, offers its index/address on a
// valid/ready handshake, then pulses desativar_out so the upstream
// manager retires it. A guard cycle follows before the next arbitration.
// Optional build macro DESPACHANTE_CONTADOR_EN enables a 16-bit count of
// accepted offers on contagem_out; without it the port is tied to zero.
module despachante_ativos #(
  parameter int unsigned NUM_NA    = 8,
  parameter int unsigned ADR_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_NA-1:0]             habilitar_in,
  input  logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_in,
  input  logic                          pronto_in,
  output logic                          valido_out,
  output logic [$clog2(NUM_NA)-1:0]     na_sel_out,
  output logic [ADR_WIDTH-1:0]          endereco_out,
  output logic                          desativar_out,
  output logic                          ocupado_out,
  output logic [15:0]                   contagem_out
);

  localparam int unsigned SEL_WIDTH = $clog2(NUM_NA);
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    OFERTA   = 2'd1,
    DESATIVA = 2'd2,
    GUARDA   = 2'd3
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic                   valido_q, valido_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic                   desat_q, desat_d;
  logic                   ocup_q, ocup_d;

  logic [ADR_WIDTH-1:0]   adr_arr [NUM_NA];
  logic [SEL_WIDTH-1:0]   vencedor_c;
  logic                   tem_pedido_c;
  logic                   aceita_c;

  // Unpack the flat address bus into one entry per NA.
  always_comb begin
    for (int unsigned i = 0; i < NUM_NA; i++) begin
      adr_arr[i] = na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH];
    end
  end

  // Round-robin search: first set bit at or above ptr, wrapping to 0.
  always_comb begin
    int unsigned idx;
    vencedor_c   = '0;
    tem_pedido_c = 1'b0;
    idx          = 0;
    for (int unsigned k = 0; k < NUM_NA; k++) begin
      idx = (32'(ptr_q) + k) % NUM_NA;
      if (!tem_pedido_c && habilitar_in[SEL_WIDTH'(idx)]) begin
        vencedor_c   = SEL_WIDTH'(idx);
        tem_pedido_c = 1'b1;
      end
    end
  end

  assign aceita_c = (estado_q == OFERTA) && valido_q && pronto_in;

  // Next-state and registered-output computation.
  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    valido_d = valido_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    desat_d  = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (tem_pedido_c) begin
          estado_d = OFERTA;
          valido_d = 1'b1;
          sel_d    = vencedor_c;
          adr_d    = adr_arr[vencedor_c];
        end
      end
      OFERTA: begin
        if (aceita_c) begin
          estado_d = DESATIVA;
          valido_d = 1'b0;
          desat_d  = 1'b1;
          ptr_d    = (sel_q == SEL_WIDTH'(NUM_NA - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
        end
      end
      DESATIVA: begin
        estado_d = GUARDA;
      end
      GUARDA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
        valido_d = 1'b0;
      end
    endcase
    ocup_d = (estado_d != OCIOSO);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      ptr_q    <= '0;
      valido_q <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      desat_q  <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
      valido_q <= valido_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      desat_q  <= desat_d;
      ocup_q   <= ocup_d;
    end
  end

  assign valido_out    = valido_q;
  assign na_sel_out    = sel_q;
  assign endereco_out  = adr_q;
  assign desativar_out = desat_q;
  assign ocupado_out   = ocup_q;

`ifdef DESPACHANTE_CONTADOR_EN
  logic [CNT_WIDTH-1:0] cont_q, cont_d;

  // Count accepted offers; wraps naturally at 16 bits.
  always_comb begin
    cont_d = cont_q;
    if (aceita_c) begin
      cont_d = cont_q + CNT_WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q <= '0;
    end else begin
      cont_q <= cont_d;
    end
  end

  assign contagem_out = cont_q;
`else
  assign contagem_out = CNT_WIDTH'(0);
`endif

endmodule

// File: tb/tb_despachante_ativos.sv
// Self-checking bench for despachante_ativos: per-cycle vector table,
// plus scoreboard-driven round-robin, backpressure and wrap sequences.
module tb_despachante_ativos;

  localparam int unsigned NUM_NA    = 8;
  localparam int unsigned ADR_WIDTH = 5;
  localparam int unsigned SEL_WIDTH = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_NA-1:0]           habilitar_in;
  logic [ADR_WIDTH*NUM_NA-1:0] na_endereco_in;
  logic                        pronto_in;
  logic                        valido_out;
  logic [SEL_WIDTH-1:0]        na_sel_out;
  logic [ADR_WIDTH-1:0]        endereco_out;
  logic                        desativar_out;
  logic                        ocupado_out;
  logic [15:0]                 contagem_out;

  always #5 clk = ~clk;

  despachante_ativos #(.NUM_NA(NUM_NA), .ADR_WIDTH(ADR_WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .habilitar_in   (habilitar_in),
    .na_endereco_in (na_endereco_in),
    .pronto_in      (pronto_in),
    .valido_out     (valido_out),
    .na_sel_out     (na_sel_out),
    .endereco_out   (endereco_out),
    .desativar_out  (desativar_out),
    .ocupado_out    (ocupado_out),
    .contagem_out   (contagem_out)
  );

  typedef struct {
    logic [SEL_WIDTH-1:0] sel;
    logic [ADR_WIDTH-1:0] adr;
  } exp_t;

  typedef struct {
    logic                 rst;
    logic [NUM_NA-1:0]    hab;
    logic                 pronto;
    logic                 valido;
    logic                 desat;
    logic                 ocup;
    logic                 chk_sel;
    logic [SEL_WIDTH-1:0] sel;
    logic [ADR_WIDTH-1:0] adr;
  } vec_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_offer_cyc = -1;
  bit   sb_en  = 1'b0;
  bit   gap_en = 1'b0;
  logic [ADR_WIDTH-1:0] last_adr = '0;
  logic [15:0]          exp_cnt  = '0;

  // NA i carries address 3*i+2 (NA5 -> 17).
  function automatic logic [ADR_WIDTH-1:0] adr_of(int i);
    return ADR_WIDTH'(3 * i + 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: derive expectations from pre-edge state, then check post-edge.
  task automatic tick();
    logic acc, hold, pv;
    logic [SEL_WIDTH-1:0] ps;
    logic [ADR_WIDTH-1:0] pa;
    exp_t e;
    acc  = (valido_out === 1'b1) && pronto_in && !rst;
    hold = (valido_out === 1'b1) && !pronto_in && !rst;
    pv   = valido_out;
    ps   = na_sel_out;
    pa   = endereco_out;
`ifdef DESPACHANTE_CONTADOR_EN
    if (rst) exp_cnt = '0;
    else if (acc) exp_cnt = exp_cnt + 16'd1;
`endif
    @(posedge clk);
    #1;
    cyc++;
    chk("desativar_pulse", 32'(desativar_out), 32'(acc));
    chk("contagem", 32'(contagem_out), 32'(exp_cnt));
    if (hold) begin
      chk("offer_held_valido", 32'(valido_out), 32'd1);
      chk("offer_held_sel", 32'(na_sel_out), 32'(ps));
      chk("offer_held_adr", 32'(endereco_out), 32'(pa));
    end
    if (desativar_out === 1'b1) begin
      chk("retire_adr", 32'(endereco_out), 32'(last_adr));
    end
    if (valido_out === 1'b1 && pv !== 1'b1) begin
      last_adr = endereco_out;
      if (sb_en) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_offer", 32'(na_sel_out), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("offer_sel", 32'(na_sel_out), 32'(e.sel));
          chk("offer_adr", 32'(endereco_out), 32'(e.adr));
        end
        if (gap_en && last_offer_cyc >= 0) begin
          chk("offer_spacing", 32'(cyc - last_offer_cyc), 32'd4);
        end
        last_offer_cyc = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_offer_cyc = -1;
  endtask

  task automatic push(input int i);
    exp_t e;
    e.sel = SEL_WIDTH'(i);
    e.adr = adr_of(i);
    sb_q.push_back(e);
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic drain();
    habilitar_in = '0;
    pronto_in    = 1'b1;
    repeat (4) tick();
    chk("idle_after_drain", 32'(ocupado_out), 32'd0);
  endtask

  vec_t vt[16];

  initial begin
    rst          = 1'b1;
    habilitar_in = '0;
    pronto_in    = 1'b0;
    for (int i = 0; i < int'(NUM_NA); i++) begin
      na_endereco_in[i*ADR_WIDTH +: ADR_WIDTH] = adr_of(i);
    end

    // rst hab pronto | valido desat ocup chk sel adr
    vt[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0};
    vt[1]  = '{1'b0, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 5'd17};
    vt[2]  = '{1'b0, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 5'd17};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0};
    vt[5]  = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd8};
    vt[6]  = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd8};
    vt[7]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 5'd0};
    vt[8]  = '{1'b0, 8'h06, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 5'd5};
    vt[9]  = '{1'b0, 8'h06, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 5'd5};
    vt[10] = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0};
    vt[11] = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0};
    vt[12] = '{1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 5'd8};
    vt[13] = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 5'd8};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 5'd0};
    vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0};

    // Reset, single NA and reset-mid-offer vectors.
    for (int r = 0; r < 16; r++) begin
      rst          = vt[r].rst;
      habilitar_in = vt[r].hab;
      pronto_in    = vt[r].pronto;
      tick();
      chk($sformatf("vec%0d_valido", r), 32'(valido_out), 32'(vt[r].valido));
      chk($sformatf("vec%0d_desat", r), 32'(desativar_out), 32'(vt[r].desat));
      chk($sformatf("vec%0d_ocupado", r), 32'(ocupado_out), 32'(vt[r].ocup));
      if (vt[r].chk_sel) begin
        chk($sformatf("vec%0d_sel", r), 32'(na_sel_out), 32'(vt[r].sel));
        chk($sformatf("vec%0d_adr", r), 32'(endereco_out), 32'(vt[r].adr));
      end
    end
    rst = 1'b0;

    // Round-robin over all NAs with the 4-cycle cadence.
    sb_en  = 1'b1;
    gap_en = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push(i);
    push(0);
    habilitar_in = 8'hFF;
    pronto_in    = 1'b1;
    run_until_empty(60);
    drain();
    gap_en = 1'b0;

    // Backpressure: offer held while bit 0 drops, then NA 3 follows.
    do_reset();
    push(0);
    push(3);
    habilitar_in = 8'b0000_1001;
    pronto_in    = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) habilitar_in = 8'b0000_1000;
      tick();
      chk("bp_valido", 32'(valido_out), 32'd1);
      chk("bp_sel", 32'(na_sel_out), 32'd0);
    end
    pronto_in = 1'b1;
    run_until_empty(20);
    drain();

    // Wrap from the top of the pointer range.
    do_reset();
    push(6);
    habilitar_in = 8'b0100_0000;
    pronto_in    = 1'b1;
    run_until_empty(10);
    drain();
    push(0);
    push(1);
    habilitar_in = 8'b0000_0011;
    pronto_in    = 1'b1;
    run_until_empty(20);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
